fifo_slave_seq: RTL and testbench



---
 rtl/fifo_slave_seq.sv | 170 +++++++++++++++++
 tb/tb_fifo_slave_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_slave_seq.sv
// Sequences pops/pushes on the Pi side of the two 8-bit CPC<->Pi FIFO pairs over a shared sd bus.
// Latency: flag-to-strobe = 2 sync + 1 IDLE + SETUP_CYCLES; every access ends with RECOVER_CYCLES.
// Backpressure: no pop while rx_valid=1; tx_ready pulses for one cycle only when a push is granted.
//
// Ports:
//   CLK, RESET                      clock, synchronous active-high reset
//   fifo_slave_dor/dir              async FIFO flags (data out ready / data in ready)
//   sd_in, sd_out, sd_oe            shared sd bus: read value, driven value, drive enable
//   slave_fifo_si/sob/wnr           shift-in (high), shift-out (low), write-not-read direction
//   rx_data/rx_valid/rx_ready       popped-byte stream towards Pi logic
//   tx_data/tx_valid/tx_ready       byte stream from Pi logic to be pushed
module fifo_slave_seq #(
    parameter int STROBE_CYCLES  = 2,
    parameter int SETUP_CYCLES   = 2,
    parameter int RECOVER_CYCLES = 6,
    parameter int CNT_W          = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       fifo_slave_dor,
    input  logic       fifo_slave_dir,
    input  logic [7:0] sd_in,
    output logic [7:0] sd_out,
    output logic       sd_oe,
    output logic       slave_fifo_si,
    output logic       slave_fifo_sob,
    output logic       slave_fifo_wnr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready
);

    typedef enum logic [3:0] {
        IDLE,
        RD_SETUP,
        RD_STROBE,
        RD_RECOVER,
        WR_TURN,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        WR_RELEASE,
        WR_RECOVER
    } state_t;

    localparam logic [CNT_W-1:0] ST_LD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SU_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] RC_LD = CNT_W'(RECOVER_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             dor_m_q, dor_s_q, dir_m_q, dir_s_q;
    logic             last_rd_q, last_rd_d;
    logic [7:0]       tx_byte_q, tx_byte_d;
    logic [7:0]       rx_data_q, rx_data_d;
    logic             rx_valid_q, rx_valid_d;
    logic             si_q, sob_q, wnr_q, oe_q;
    logic             si_d, sob_d, wnr_d, oe_d;
    logic             rd_req, wr_req, grant_rd, grant_wr;

    always_comb begin
        state_d    = state_q;
        cnt_d      = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
        last_rd_d  = last_rd_q;
        tx_byte_d  = tx_byte_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        tx_ready   = 1'b0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        rd_req   = dor_s_q & ~rx_valid_q;
        wr_req   = dir_s_q & tx_valid;
        // Round-robin: on a tie, serve whichever side did not win last time.
        grant_rd = rd_req & (~wr_req | ~last_rd_q);
        grant_wr = wr_req & (~rd_req | last_rd_q);

        case (state_q)
            IDLE: begin
                if (grant_rd) begin
                    state_d   = RD_SETUP;
                    cnt_d     = SU_LD;
                    last_rd_d = 1'b1;
                end else if (grant_wr) begin
                    state_d   = WR_TURN;
                    cnt_d     = '0;
                    last_rd_d = 1'b0;
                    tx_byte_d = tx_data;
                    tx_ready  = ~RESET;
                end
            end
            RD_SETUP: if (cnt_q == '0) begin
                // Data has had SETUP_CYCLES to settle; capture as the strobe starts.
                state_d    = RD_STROBE;
                cnt_d      = ST_LD;
                rx_data_d  = sd_in;
                rx_valid_d = 1'b1;
            end
            RD_STROBE:  if (cnt_q == '0) begin state_d = RD_RECOVER; cnt_d = RC_LD; end
            RD_RECOVER: if (cnt_q == '0) begin state_d = IDLE;       cnt_d = '0;    end
            WR_TURN:    if (cnt_q == '0) begin state_d = WR_SETUP;   cnt_d = SU_LD; end
            WR_SETUP:   if (cnt_q == '0) begin state_d = WR_STROBE;  cnt_d = ST_LD; end
            WR_STROBE:  if (cnt_q == '0) begin state_d = WR_HOLD;    cnt_d = SU_LD; end
            WR_HOLD:    if (cnt_q == '0) begin state_d = WR_RELEASE; cnt_d = '0;    end
            WR_RELEASE: if (cnt_q == '0) begin state_d = WR_RECOVER; cnt_d = RC_LD; end
            WR_RECOVER: if (cnt_q == '0) begin state_d = IDLE;       cnt_d = '0;    end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Pin levels are decoded from the next state and registered, so they
        // change on the same edge as the state and never glitch.
        sob_d = (state_d != RD_STROBE);
        si_d  = (state_d == WR_STROBE);
        oe_d  = (state_d == WR_SETUP) || (state_d == WR_STROBE) || (state_d == WR_HOLD);
        // WR_TURN and WR_RELEASE bracket the driven window so the FIFO outputs are
        // off a cycle before we drive and stay off a cycle after we release.
        wnr_d = oe_d || (state_d == WR_TURN) || (state_d == WR_RELEASE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dor_m_q    <= 1'b0;
            dor_s_q    <= 1'b0;
            dir_m_q    <= 1'b0;
            dir_s_q    <= 1'b0;
            last_rd_q  <= 1'b0;
            tx_byte_q  <= 8'h00;
            rx_data_q  <= 8'h00;
            rx_valid_q <= 1'b0;
            si_q       <= 1'b0;
            sob_q      <= 1'b1;
            wnr_q      <= 1'b0;
            oe_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dor_m_q    <= fifo_slave_dor;
            dor_s_q    <= dor_m_q;
            dir_m_q    <= fifo_slave_dir;
            dir_s_q    <= dir_m_q;
            last_rd_q  <= last_rd_d;
            tx_byte_q  <= tx_byte_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            si_q       <= si_d;
            sob_q      <= sob_d;
            wnr_q      <= wnr_d;
            oe_q       <= oe_d;
        end
    end

    assign sd_out         = tx_byte_q;
    assign sd_oe          = oe_q;
    assign slave_fifo_si  = si_q;
    assign slave_fifo_sob = sob_q;
    assign slave_fifo_wnr = wnr_q;
    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;

endmodule

// File: tb/tb_fifo_slave_seq.sv
// Bench for fifo_slave_seq: two instances (default timing and STROBE=1/SETUP=1/RECOVER=3)
// share stimulus; an access-level timeline model predicts every pin each cycle.
module tb_fifo_slave_seq;
    localparam int NDUT = 2;

    logic       CLK = 1'b0;
    logic       RESET, dor, dir, rx_ready, tx_valid;
    logic [7:0] sd_in, tx_data;

    logic [7:0] sd_out_w [NDUT];
    logic [7:0] rxd_w    [NDUT];
    logic [NDUT-1:0] oe_w, si_w, sob_w, wnr_w, rxv_w, txr_w;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    fifo_slave_seq #(.STROBE_CYCLES(2), .SETUP_CYCLES(2), .RECOVER_CYCLES(6), .CNT_W(4)) u_dut0 (
        .CLK(CLK), .RESET(RESET), .fifo_slave_dor(dor), .fifo_slave_dir(dir), .sd_in(sd_in),
        .sd_out(sd_out_w[0]), .sd_oe(oe_w[0]), .slave_fifo_si(si_w[0]), .slave_fifo_sob(sob_w[0]),
        .slave_fifo_wnr(wnr_w[0]), .rx_data(rxd_w[0]), .rx_valid(rxv_w[0]), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_w[0]));

    fifo_slave_seq #(.STROBE_CYCLES(1), .SETUP_CYCLES(1), .RECOVER_CYCLES(3), .CNT_W(4)) u_dut1 (
        .CLK(CLK), .RESET(RESET), .fifo_slave_dor(dor), .fifo_slave_dir(dir), .sd_in(sd_in),
        .sd_out(sd_out_w[1]), .sd_oe(oe_w[1]), .slave_fifo_si(si_w[1]), .slave_fifo_sob(sob_w[1]),
        .slave_fifo_wnr(wnr_w[1]), .rx_data(rxd_w[1]), .rx_valid(rxv_w[1]), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(txr_w[1]));

    function automatic int p_st(input int d); return (d == 0) ? 2 : 1; endfunction
    function automatic int p_su(input int d); return (d == 0) ? 2 : 1; endfunction
    function automatic int p_rc(input int d); return (d == 0) ? 6 : 3; endfunction
    function automatic int rd_len(input int d); return p_su(d) + p_st(d) + p_rc(d); endfunction
    function automatic int wr_len(input int d); return 2 * p_su(d) + p_st(d) + 2 + p_rc(d); endfunction

    // Model: an access is "busy for len cycles starting at offset 0"; pins follow from the offset.
    logic       m_busy [NDUT], m_rd [NDUT], m_last_rd [NDUT], m_rxv [NDUT];
    logic       m_dor1 [NDUT], m_dors [NDUT], m_dir1 [NDUT], m_dirs [NDUT];
    int         m_k    [NDUT];
    logic [7:0] m_txb  [NDUT], m_rxd [NDUT];
    logic       prev_wnr [NDUT];
    logic [NDUT-1:0] txr_seen;

    function automatic int m_grant(input int d, input logic txv);
        logic rq, wq;
        rq = m_dors[d] & ~m_rxv[d];
        wq = m_dirs[d] & txv;
        if (m_busy[d]) return 0;
        if (rq && wq) return m_last_rd[d] ? 2 : 1;
        if (rq) return 1;
        if (wq) return 2;
        return 0;
    endfunction

    function automatic logic m_txr(input int d);
        return ~RESET & (m_grant(d, tx_valid) == 2);
    endfunction

    // {sob, si, wnr, oe}
    function automatic logic [3:0] m_out(input int d);
        int k, su, st;
        k = m_k[d]; su = p_su(d); st = p_st(d);
        if (!m_busy[d]) return 4'b1000;
        if (m_rd[d]) return (k >= su && k < su + st) ? 4'b0000 : 4'b1000;
        if (k == 0) return 4'b1010;
        if (k < 1 + su) return 4'b1011;
        if (k < 1 + su + st) return 4'b1111;
        if (k < 1 + 2 * su + st) return 4'b1011;
        if (k == 1 + 2 * su + st) return 4'b1010;
        return 4'b1000;
    endfunction

    task automatic m_edge(input int d);
        int g;
        if (RESET) begin
            m_busy[d] = 0; m_rd[d] = 0; m_last_rd[d] = 0; m_rxv[d] = 0; m_k[d] = 0;
            m_txb[d] = 8'h00; m_rxd[d] = 8'h00;
            m_dor1[d] = 0; m_dors[d] = 0; m_dir1[d] = 0; m_dirs[d] = 0;
            return;
        end
        g = m_grant(d, tx_valid);
        if (m_rxv[d] && rx_ready) m_rxv[d] = 0;
        if (g != 0) begin
            m_busy[d] = 1; m_k[d] = 0; m_rd[d] = (g == 1); m_last_rd[d] = (g == 1);
            if (g == 2) m_txb[d] = tx_data;
        end else if (m_busy[d]) begin
            if (m_rd[d] && m_k[d] == p_su(d) - 1) begin
                m_rxd[d] = sd_in;
                m_rxv[d] = 1;
            end
            if (m_k[d] == (m_rd[d] ? rd_len(d) : wr_len(d)) - 1) m_busy[d] = 0;
            else m_k[d] = m_k[d] + 1;
        end
        m_dors[d] = m_dor1[d]; m_dor1[d] = dor;
        m_dirs[d] = m_dir1[d]; m_dir1[d] = dir;
    endtask

    task automatic chk1(input string name, input int d, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %b expected %b", name, d, $time, act, exp);
        end
    endtask

    task automatic chk32(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d t=%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    // Called at a negedge: drive, check combinational tx_ready, clock, check registered pins.
    task automatic step(input logic rst, input logic dr, input logic di, input logic tv,
                        input logic [7:0] td, input logic rr, input logic [7:0] sdi);
        logic [3:0] eo;
        RESET = rst; dor = dr; dir = di; tx_valid = tv; tx_data = td; rx_ready = rr; sd_in = sdi;
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk1("tx_ready", d, txr_w[d], m_txr(d));
            txr_seen[d] = txr_w[d];
        end
        @(posedge CLK);
        for (int d = 0; d < NDUT; d++) m_edge(d);
        @(negedge CLK);
        for (int d = 0; d < NDUT; d++) begin
            eo = m_out(d);
            chk1("sob", d, sob_w[d], eo[3]);
            chk1("si", d, si_w[d], eo[2]);
            chk1("wnr", d, wnr_w[d], eo[1]);
            chk1("sd_oe", d, oe_w[d], eo[0]);
            chk1("rx_valid", d, rxv_w[d], m_rxv[d]);
            chk32("rx_data", d, 32'(rxd_w[d]), 32'(m_rxd[d]));
            chk32("sd_out", d, 32'(sd_out_w[d]), 32'(m_txb[d]));
            if (oe_w[d]) chk1("oe_implies_wnr_now_and_prev", d, wnr_w[d] & prev_wnr[d], 1'b1);
            prev_wnr[d] = wnr_w[d];
        end
    endtask

    typedef struct packed {
        logic       dor;
        logic       rxr;
        logic [7:0] sdi;
        logic       exp_sob;
        logic       exp_rxv;
        logic [7:0] exp_rxd;
    } vec_t;

    vec_t vt [14];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, got, j, ok;
        int lastkind [NDUT];
        int pops [NDUT], pushes [NDUT], last_pop_t [NDUT];
        logic psob [NDUT], psi [NDUT];

        // Single pop on the default-timing instance, dor raised just before edge 0.
        vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vt[1]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vt[2]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00};
        vt[3]  = '{1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 8'h00};
        vt[4]  = '{1'b1, 1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5};
        vt[5]  = '{1'b1, 1'b0, 8'h5A, 1'b0, 1'b1, 8'hA5};
        vt[6]  = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'hA5};
        vt[7]  = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'hA5};
        vt[8]  = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'hA5};
        vt[9]  = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'hA5};
        vt[10] = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'hA5};
        vt[11] = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'hA5};
        vt[12] = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'hA5};
        vt[13] = '{1'b1, 1'b0, 8'h5A, 1'b1, 1'b1, 8'hA5};

        for (int d = 0; d < NDUT; d++) prev_wnr[d] = 1'b0;
        RESET = 1'b1; dor = 0; dir = 0; rx_ready = 0; tx_valid = 0; tx_data = 0; sd_in = 0;
        @(negedge CLK);
        step(1, 0, 0, 0, 8'h00, 0, 8'h00);
        step(1, 0, 0, 0, 8'h00, 0, 8'h00);
        for (int d = 0; d < NDUT; d++) begin
            chk1("reset_sob", d, sob_w[d], 1'b1);
            chk1("reset_wnr", d, wnr_w[d], 1'b0);
            chk32("reset_rx_data", d, 32'(rxd_w[d]), 32'h0);
            chk32("reset_sd_out", d, 32'(sd_out_w[d]), 32'h0);
        end

        for (int i = 0; i < 14; i++) begin
            step(0, vt[i].dor, 0, 0, 8'h00, vt[i].rxr, vt[i].sdi);
            chk1("tbl_sob", 0, sob_w[0], vt[i].exp_sob);
            chk1("tbl_rx_valid", 0, rxv_w[0], vt[i].exp_rxv);
            if (vt[i].exp_rxv) chk32("tbl_rx_data", 0, 32'(rxd_w[0]), 32'(vt[i].exp_rxd));
        end

        // dor held high while rx_valid=1: no further pop.
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0, 0, 8'h00, 0, 8'h77);
            if (!sob_w[0]) cnt++;
        end
        chk32("no_pop_while_rx_valid", 0, cnt, 0);
        step(0, 0, 0, 0, 8'h00, 1, 8'h00);
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0, 8'h00, 0, 8'h00);

        // dir low gates the push; raising dir starts it after the 2-flop sync.
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1, 8'h3C, 0, 8'h00);
            cnt = cnt + int'(txr_seen[0]) + int'(si_w[0]);
        end
        chk32("no_push_while_dir_low", 0, cnt, 0);
        got = 0; j = -1;
        for (int i = 0; i < 10 && got == 0; i++) begin
            step(0, 0, 1, 1, 8'h3C, 0, 8'h00);
            if (txr_seen[0]) begin got = 1; j = i; end
        end
        chk1("tx_ready_seen", 0, got == 1, 1'b1);
        chk32("tx_ready_after_sync", 0, j, 2);
        chk1("wnr_first_after_grant", 0, wnr_w[0] & ~oe_w[0], 1'b1);
        cnt = 0; ok = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 1, 0, 8'h00, 0, 8'h00);
            if (si_w[0]) cnt++;
            if (si_w[0] && !psi[0]) ok++;
            if (oe_w[0]) chk32("push_sd_out", 0, 32'(sd_out_w[0]), 32'h3C);
            psi[0] = si_w[0];
        end
        chk32("si_high_cycles", 0, cnt, 2);
        chk32("si_pulse_count", 0, ok, 1);

        // Reset while si is high.
        got = 0;
        for (int i = 0; i < 40 && got == 0; i++) begin
            step(0, 0, 1, 1, 8'h96, 0, 8'h00);
            if (si_w[0]) got = 1;
        end
        chk1("reached_wr_strobe", 0, got == 1, 1'b1);
        step(1, 0, 1, 1, 8'h96, 0, 8'h00);
        chk1("rst_mid_si", 0, si_w[0], 1'b0);
        chk1("rst_mid_oe", 0, oe_w[0], 1'b0);
        chk1("rst_mid_wnr", 0, wnr_w[0], 1'b0);
        chk1("rst_mid_sob", 0, sob_w[0], 1'b1);
        chk1("rst_mid_rx_valid", 0, rxv_w[0], 1'b0);

        // Contention: both flags high, producer and consumer always ready.
        for (int d = 0; d < NDUT; d++) begin
            lastkind[d] = 0; pops[d] = 0; pushes[d] = 0; last_pop_t[d] = 0;
            psob[d] = 1'b1; psi[d] = 1'b0;
        end
        for (int c = 0; c < 160; c++) begin
            step(0, 1, 1, 1, 8'($urandom), 1, 8'($urandom));
            for (int d = 0; d < NDUT; d++) begin
                if (psob[d] && !sob_w[d]) begin
                    if (lastkind[d] == 0) chk32("first_grant_is_rd", d, 1, 32'(lastkind[d] + 1));
                    else chk1("alternate_after_wr", d, lastkind[d] == 2, 1'b1);
                    if (pops[d] > 0)
                        chk32("rd_to_rd_period", d, c - last_pop_t[d], rd_len(d) + wr_len(d) + 2);
                    last_pop_t[d] = c; pops[d]++; lastkind[d] = 1;
                end
                if (!psi[d] && si_w[d]) begin
                    chk1("alternate_after_rd", d, lastkind[d] == 1, 1'b1);
                    pushes[d]++; lastkind[d] = 2;
                end
                psob[d] = sob_w[d]; psi[d] = si_w[d];
            end
        end
        for (int d = 0; d < NDUT; d++) begin
            chk1("contention_pops_ge4", d, pops[d] >= 4, 1'b1);
            chk1("contention_pushes_ge4", d, pushes[d] >= 4, 1'b1);
        end

        // Randomised traffic, including occasional resets.
        for (int n = 0; n < 3000; n++) begin
            logic r, a, b, v, q;
            r = ($urandom_range(0, 299) == 0);
            a = ($urandom_range(0, 9) < 6);
            b = ($urandom_range(0, 9) < 7);
            v = ($urandom_range(0, 9) < 6);
            q = ($urandom_range(0, 9) < 4);
            step(r, a, b, v, 8'($urandom), q, 8'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
